// File: rtl/inst_fetch_queue.sv
// Fetch queue: compacts up to 8 valid lanes per packet into a circular buffer and presents two decode slots.
// One cycle from accept to visibility, with no bypass; FqStall holds off a packet while fewer than 8 entries are free.
module inst_fetch_queue #(
  parameter int FQ_DEPTH = 16
) (
  input  logic         Clk,
  input  logic         Rest,
  input  logic         InFlash,
  input  logic         InAble,
  input  logic [255:0] InPcIvt,
  input  logic [7:0]   InInstIvt,
  input  logic [255:0] InDate,
  output logic         FqStall,
  input  logic         InDecReady,
  output logic         OutAble0,
  output logic         OutAble1,
  output logic [31:0]  OutPc0,
  output logic [31:0]  OutPc1,
  output logic [31:0]  OutInst0,
  output logic [31:0]  OutInst1
);

  localparam int AW = $clog2(FQ_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_pc   [FQ_DEPTH];
  logic [31:0]   r_inst [FQ_DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_enq;
  logic [1:0]    w_deq;
  logic [3:0]    w_pop;
  logic [3:0]    w_acc;
  logic [2:0]    w_off [8];
  logic [AW-1:0] w_head1;

  assign FqStall = r_count > CW'(FQ_DEPTH - 8);
  assign w_enq   = InAble && !FqStall && !InFlash;

  always_comb begin
    w_deq = 2'd0;
    if (InDecReady) begin
      w_deq = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
    end
  end

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    w_acc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_off[i] = w_acc[2:0];
      w_acc    = w_acc + {3'b000, InInstIvt[i]};
    end
    w_pop = w_acc;
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        r_pc[i]   <= '0;
        r_inst[i] <= '0;
      end
    end else if (InFlash) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        for (int i = 0; i < 8; i++) begin
          if (InInstIvt[i]) begin
            r_pc[r_tail + AW'(w_off[i])]   <= InPcIvt[32*i +: 32];
            r_inst[r_tail + AW'(w_off[i])] <= InDate[32*i +: 32];
          end
        end
      end
      r_tail  <= r_tail + (w_enq ? AW'(w_pop) : AW'(0));
      r_head  <= r_head + AW'(w_deq);
      r_count <= r_count + (w_enq ? CW'(w_pop) : CW'(0)) - CW'(w_deq);
    end
  end

  assign w_head1  = r_head + AW'(1);
  assign OutAble0 = r_count != '0;
  assign OutAble1 = r_count >= CW'(2);
  assign OutPc0   = OutAble0 ? r_pc[r_head]    : '0;
  assign OutInst0 = OutAble0 ? r_inst[r_head]  : '0;
  assign OutPc1   = OutAble1 ? r_pc[w_head1]   : '0;
  assign OutInst1 = OutAble1 ? r_inst[w_head1] : '0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: scoreboard queue model, a vector table, and hand-written corner sequences.
module tb_inst_fetch_queue;

  logic         Clk;
  logic         Rest;
  logic         InFlash;
  logic         InAble;
  logic [255:0] InPcIvt;
  logic [7:0]   InInstIvt;
  logic [255:0] InDate;
  logic         FqStall;
  logic         InDecReady;
  logic         OutAble0;
  logic         OutAble1;
  logic [31:0]  OutPc0;
  logic [31:0]  OutPc1;
  logic [31:0]  OutInst0;
  logic [31:0]  OutInst1;

  inst_fetch_queue #(.FQ_DEPTH(16)) dut (
    .Clk(Clk), .Rest(Rest), .InFlash(InFlash), .InAble(InAble),
    .InPcIvt(InPcIvt), .InInstIvt(InInstIvt), .InDate(InDate),
    .FqStall(FqStall), .InDecReady(InDecReady),
    .OutAble0(OutAble0), .OutAble1(OutAble1),
    .OutPc0(OutPc0), .OutPc1(OutPc1),
    .OutInst0(OutInst0), .OutInst1(OutInst1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  typedef struct packed {
    logic       able;
    logic [7:0] mask;
    logic       rdy;
    logic       fl;
    logic [4:0] cnt;
    logic       stall;
  } vec_t;

  ent_t q[$];
  vec_t tbl [14];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; outputs are checked against the model before the edge.
  task automatic cycle(input logic able, input logic [7:0] mask, input logic rdy,
                       input logic fl, input logic [31:0] pc_base, input logic [31:0] inst_base);
    int   ndeq;
    logic stall_m;
    ent_t e;
    InAble     = able;
    InInstIvt  = mask;
    InDecReady = rdy;
    InFlash    = fl;
    for (int i = 0; i < 8; i++) begin
      InPcIvt[32*i +: 32] = pc_base + 32'(4 * i);
      InDate[32*i +: 32]  = inst_base + 32'(i);
    end
    #1;
    stall_m = q.size() > 8;
    chk("count", 64'(dut.r_count), 64'(q.size()));
    chk("stall", 64'(FqStall), 64'(stall_m));
    chk("able0", 64'(OutAble0), 64'(q.size() >= 1));
    chk("able1", 64'(OutAble1), 64'(q.size() >= 2));
    if (q.size() >= 1) begin
      chk("pc0", 64'(OutPc0), 64'(q[0].pc));
      chk("inst0", 64'(OutInst0), 64'(q[0].inst));
    end else begin
      chk("pc0_zero", 64'(OutPc0), 64'd0);
      chk("inst0_zero", 64'(OutInst0), 64'd0);
    end
    if (q.size() >= 2) begin
      chk("pc1", 64'(OutPc1), 64'(q[1].pc));
      chk("inst1", 64'(OutInst1), 64'(q[1].inst));
    end else begin
      chk("pc1_zero", 64'(OutPc1), 64'd0);
      chk("inst1_zero", 64'(OutInst1), 64'd0);
    end
    if (fl) begin
      q.delete();
    end else begin
      ndeq = rdy ? ((q.size() >= 2) ? 2 : q.size()) : 0;
      repeat (ndeq) void'(q.pop_front());
      if (able && !stall_m) begin
        for (int i = 0; i < 8; i++) begin
          if (mask[i]) begin
            e.pc   = pc_base + 32'(4 * i);
            e.inst = inst_base + 32'(i);
            q.push_back(e);
          end
        end
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rest       = 1'b0;
    InAble     = 1'b0;
    InFlash    = 1'b0;
    InDecReady = 1'b0;
    InInstIvt  = 8'h00;
    @(posedge Clk);
    #1;
    @(negedge Clk);
    Rest = 1'b1;
    @(posedge Clk);
    #1;
    q.delete();
  endtask

  initial begin
    Rest = 1'b0; InFlash = 1'b0; InAble = 1'b0; InDecReady = 1'b0;
    InPcIvt = '0; InInstIvt = '0; InDate = '0;
    #12;
    chk("rst_stall", 64'(FqStall), 64'd0);
    chk("rst_able", 64'({OutAble0, OutAble1}), 64'd0);
    chk("rst_pc", 64'({OutPc0, OutPc1}), 64'd0);
    chk("rst_inst", 64'({OutInst0, OutInst1}), 64'd0);
    do_reset();

    // able, mask, rdy, flush, count after the cycle, stall after the cycle
    tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 5'd8, 1'b0};
    tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b0, 5'd9, 1'b1};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 5'd9, 1'b1};
    tbl[3]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 5'd7, 1'b0};
    tbl[4]  = '{1'b0, 8'hFF, 1'b1, 1'b0, 5'd5, 1'b0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 5'd5, 1'b0};
    tbl[6]  = '{1'b1, 8'h81, 1'b1, 1'b0, 5'd5, 1'b0};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd3, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b0};
    tbl[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 5'd8, 1'b0};
    tbl[12] = '{1'b1, 8'h0F, 1'b1, 1'b1, 5'd0, 1'b0};
    tbl[13] = '{1'b1, 8'h55, 1'b1, 1'b0, 5'd4, 1'b0};

    for (int k = 0; k < 14; k++) begin
      cycle(tbl[k].able, tbl[k].mask, tbl[k].rdy, tbl[k].fl,
            32'h1C00_0000 + 32'(k * 256), {16'hB000, 8'(k), 8'h00});
      chk($sformatf("tbl%0d_cnt", k), 64'(dut.r_count), 64'(tbl[k].cnt));
      chk($sformatf("tbl%0d_stall", k), 64'(FqStall), 64'(tbl[k].stall));
      if (k == 0) begin
        chk("first_pc0", 64'(OutPc0), 64'h1C00_0000);
        chk("first_pc1", 64'(OutPc1), 64'h1C00_0004);
      end
    end
    repeat (3) cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);

    // Sparse mask compaction
    do_reset();
    cycle(1'b1, 8'b1010_0100, 1'b0, 1'b0, 32'h0000_4000, 32'h0000_00A0);
    chk("sparse_cnt", 64'(dut.r_count), 64'd3);
    chk("sparse_i0", 64'(OutInst0), 64'hA2);
    chk("sparse_i1", 64'(OutInst1), 64'hA5);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("sparse_last_i0", 64'(OutInst0), 64'hA7);
    chk("sparse_last_a0", 64'(OutAble0), 64'd1);
    chk("sparse_last_a1", 64'(OutAble1), 64'd0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);

    // Wrap around index 15 -> 0
    do_reset();
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0000_5000, 32'h5000_0000);
    cycle(1'b1, 8'hFF, 1'b1, 1'b0, 32'h0000_5100, 32'h5100_0000);
    repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0000_5200, 32'h5200_0000);
    chk("wrap_head", 64'(dut.r_head), 64'd14);
    chk("wrap_cnt10", 64'(dut.r_count), 64'd10);
    cycle(1'b1, 8'h0F, 1'b1, 1'b0, 32'h0000_5300, 32'h5300_0000);
    chk("wrap_stalled_cnt", 64'(dut.r_count), 64'd8);
    chk("wrap_head0", 64'(dut.r_head), 64'd0);
    cycle(1'b1, 8'h0F, 1'b1, 1'b0, 32'h0000_5400, 32'h5400_0000);
    chk("wrap_cnt", 64'(dut.r_count), 64'd10);
    chk("wrap_tail", 64'(dut.r_tail), 64'd12);
    repeat (6) cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("wrap_drained", 64'(q.size()), 64'(dut.r_count));

    // Flush beats simultaneous enqueue and dequeue
    do_reset();
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0000_6000, 32'h6000_0000);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("fl_pre_cnt", 64'(dut.r_count), 64'd6);
    cycle(1'b1, 8'hFF, 1'b1, 1'b1, 32'h0000_6100, 32'h6100_0000);
    chk("fl_cnt", 64'(dut.r_count), 64'd0);
    chk("fl_able0", 64'(OutAble0), 64'd0);
    cycle(1'b1, 8'h01, 1'b0, 1'b0, 32'h0000_6200, 32'h6200_0000);
    chk("fl_tail", 64'(dut.r_tail), 64'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);

    // Asynchronous reset between edges
    do_reset();
    cycle(1'b1, 8'hFF, 1'b0, 1'b0, 32'h0000_7000, 32'h7000_0000);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b1, 8'h01, 1'b1, 1'b0, 32'h0000_7100, 32'h7100_0000);
    chk("ar_pre_cnt", 64'(dut.r_count), 64'd5);
    InAble = 1'b0; InDecReady = 1'b0; InInstIvt = 8'h00;
    #2 Rest = 1'b0;
    #1;
    chk("ar_able", 64'({OutAble0, OutAble1}), 64'd0);
    chk("ar_stall", 64'(FqStall), 64'd0);
    chk("ar_pc", 64'({OutPc0, OutPc1}), 64'd0);
    chk("ar_inst", 64'({OutInst0, OutInst1}), 64'd0);
    q.delete();
    #2 Rest = 1'b1;
    @(posedge Clk);
    #1;
    chk("ar_cnt", 64'(dut.r_count), 64'd0);
    cycle(1'b1, 8'h03, 1'b0, 1'b0, 32'h0000_7200, 32'h7200_0000);
    chk("ar_entry0", 64'(dut.r_pc[0]), 64'h0000_7200);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
